// File: rtl/npu_c_drain.sv
// C-result drain: reads 4x int32 lanes per SRAM word, requantizes them to int8 and streams packed words.
// Define NPU_C_DRAIN_RELU_EN to clamp negative lanes to zero after saturation.
module npu_c_drain #(
  parameter int FIFO_DEPTH = 2,
  parameter int IDX_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [7:0]       M,
  input  logic [7:0]       N,
  input  logic [4:0]       shift,
  output logic             busy,
  output logic             done,
  output logic             C_we,
  output logic [IDX_W-1:0] C_index,
  output logic [127:0]     C_din,
  input  logic [127:0]     C_dout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic             out_last
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

  state_t                  r_state;
  logic [7:0]              r_N;
  logic [4:0]              r_shift;
  logic [6:0]              r_B;
  logic [15:0]             r_W;
  logic [15:0]             r_issued;
  logic [6:0]              r_blk;
  logic [IDX_W-1:0]        r_cidx;
  logic                    r_vld_p1;
  logic [3:0]              r_mask_p1;
  logic                    r_last_p1;
  logic [31:0]             r_fifo_data [FIFO_DEPTH];
  logic                    r_fifo_last [FIFO_DEPTH];
  logic [PTR_W-1:0]        r_rd;
  logic [PTR_W-1:0]        r_wr;
  logic [CNT_W-1:0]        r_occ;

  logic                    w_start;
  logic                    w_pop;
  logic                    w_issue;
  logic [CNT_W:0]          w_level;
  logic [6:0]              w_B_in;
  logic [15:0]             w_W_in;
  logic [3:0]              w_mask_p0;
  logic                    w_last_p0;
  logic [31:0]             w_pack_p1;

  function automatic logic signed [32:0] round_shift(input logic signed [31:0] acc,
                                                     input logic [4:0] sh);
    logic signed [32:0] t;
    t = {acc[31], acc};
    if (sh != 5'd0) t = t + (33'sd1 <<< (sh - 5'd1));
    return t >>> sh;
  endfunction

  function automatic logic signed [7:0] sat8(input logic signed [32:0] t);
    logic signed [7:0] r;
    if (t > 33'sd127)       r = 8'sd127;
    else if (t < -33'sd128) r = 8'h80;
    else                    r = t[7:0];
`ifdef NPU_C_DRAIN_RELU_EN
    if (r < 8'sd0) r = 8'sd0;
`endif
    return r;
  endfunction

  assign w_start = (r_state == S_IDLE) && in_valid;
  assign w_B_in  = 7'(({1'b0, N} + 9'd3) >> 2);
  assign w_W_in  = 16'(M) * 16'(w_B_in);

  assign out_valid = (r_occ != '0);
  assign out_data  = out_valid ? r_fifo_data[r_rd] : 32'd0;
  assign out_last  = out_valid & r_fifo_last[r_rd];
  assign w_pop     = out_valid && out_ready;

  // Room check counts the word still in flight from the SRAM so the FIFO can never overflow.
  assign w_level = (CNT_W+1)'(r_occ) + (CNT_W+1)'(r_vld_p1) - (CNT_W+1)'(w_pop);
  assign w_issue = (r_state == S_RUN) && (r_issued < r_W) &&
                   (w_level < (CNT_W+1)'(FIFO_DEPTH));

  assign C_index = w_issue ? IDX_W'(r_issued) : r_cidx;
  assign C_we    = 1'b0;
  assign C_din   = 128'd0;
  assign busy    = (r_state == S_RUN);
  assign done    = (r_state == S_FIN);

  // p0: read issue, lane validity for the addressed column block
  always_comb begin
    w_mask_p0 = 4'd0;
    for (int i = 0; i < 4; i++) begin
      w_mask_p0[i] = (10'({r_blk, 2'b00}) + 10'(i)) < 10'(r_N);
    end
  end
  assign w_last_p0 = (r_issued == r_W - 16'd1);

  // p1: SRAM data returns, requantize and pack
  always_comb begin
    w_pack_p1 = 32'd0;
    for (int i = 0; i < 4; i++) begin
      if (r_mask_p1[i]) w_pack_p1[8*i +: 8] = sat8(round_shift(C_dout[32*i +: 32], r_shift));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_issued <= 16'd0;
      r_blk    <= 7'd0;
      r_cidx   <= '0;
      r_vld_p1 <= 1'b0;
      r_rd     <= '0;
      r_wr     <= '0;
      r_occ    <= '0;
    end else begin
      r_vld_p1 <= w_issue;
      r_occ    <= r_occ + CNT_W'(r_vld_p1) - CNT_W'(w_pop);
      if (r_vld_p1) r_wr <= (r_wr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : r_wr + 1'b1;
      if (w_pop)    r_rd <= (r_rd == PTR_W'(FIFO_DEPTH - 1)) ? '0 : r_rd + 1'b1;
      if (w_issue) begin
        r_issued <= r_issued + 16'd1;
        r_cidx   <= IDX_W'(r_issued);
        r_blk    <= (r_blk == r_B - 7'd1) ? 7'd0 : r_blk + 7'd1;
      end
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_issued <= 16'd0;
            r_blk    <= 7'd0;
            r_state  <= (M == 8'd0 || N == 8'd0) ? S_FIN : S_RUN;
          end
        end
        S_RUN:   if (w_pop && out_last) r_state <= S_FIN;
        S_FIN:   r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_start) begin
      r_N     <= N;
      r_shift <= shift;
      r_B     <= w_B_in;
      r_W     <= w_W_in;
    end
    if (w_issue) begin
      r_mask_p1 <= w_mask_p0;
      r_last_p1 <= w_last_p0;
    end
    if (r_vld_p1) begin
      r_fifo_data[r_wr] <= w_pack_p1;
      r_fifo_last[r_wr] <= r_last_p1;
    end
  end

endmodule

// File: tb/tb_npu_c_drain.sv
// Bench for npu_c_drain: directed and random transfers against a word-list reference model.
module tb_npu_c_drain;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [7:0]   M;
  logic [7:0]   N;
  logic [4:0]   shift;
  logic         busy;
  logic         done;
  logic         C_we;
  logic [15:0]  C_index;
  logic [127:0] C_din;
  logic [127:0] C_dout;
  logic         out_valid;
  logic         out_ready;
  logic [31:0]  out_data;
  logic         out_last;

  int n_assert = 0;
  int n_fail   = 0;

  logic [127:0] cmem [0:255];
  logic [31:0]  exp_q [$];
  logic [31:0]  w0;

  npu_c_drain #(.FIFO_DEPTH(2), .IDX_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .M(M), .N(N), .shift(shift),
    .busy(busy), .done(done), .C_we(C_we), .C_index(C_index), .C_din(C_din),
    .C_dout(C_dout), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last)
  );

  always #5 clk = ~clk;

  // Synchronous SRAM: data for the presented index appears the following cycle.
  always @(posedge clk) C_dout <= cmem[C_index[7:0]];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Round half-up toward +inf at 2^-sh, floor division, clamp to int8.
  function automatic logic [7:0] ref_lane(input logic [31:0] raw, input int sh);
    longint v, p, q;
    v = longint'($signed(raw));
    if (sh > 0) v = v + (longint'(1) << (sh - 1));
    p = longint'(1) << sh;
    q = v / p;
    if ((v % p != 0) && (v < 0)) q = q - 1;
    if (q > 127)  q = 127;
    if (q < -128) q = -128;
`ifdef NPU_C_DRAIN_RELU_EN
    if (q < 0) q = 0;
`endif
    return 8'(q);
  endfunction

  task automatic build_exp(input int m, input int n, input int sh);
    int b_cnt, w_cnt, blk, col;
    logic [31:0] w;
    exp_q.delete();
    b_cnt = (n + 3) / 4;
    w_cnt = m * b_cnt;
    for (int k = 0; k < w_cnt; k++) begin
      blk = k % b_cnt;
      w = 32'd0;
      for (int i = 0; i < 4; i++) begin
        col = 4 * blk + i;
        if (col < n) w[8*i +: 8] = ref_lane(cmem[k][32*i +: 32], sh);
      end
      exp_q.push_back(w);
    end
  endtask

  function automatic logic [31:0] rand_lane();
    int v;
    case ($urandom_range(0, 4))
      0: return $urandom;
      1: begin v = int'($urandom_range(0, 600)) - 300; return v; end
      2: return 32'h7FFFFFFF;
      3: return 32'h80000000;
      default: begin v = int'($urandom_range(0, 40)) - 20; return v; end
    endcase
  endfunction

  task automatic fill_rand();
    for (int k = 0; k < 256; k++)
      for (int i = 0; i < 4; i++) cmem[k][32*i +: 32] = rand_lane();
  endtask

  task automatic run(input int m, input int n, input int sh, input bit rnd_ready,
                     input int stall_at, input int stall_len, input int rst_after,
                     input int pulse_at, output logic [31:0] first_word);
    int w_cnt, got, hs_cyc, first_v, ci_hold;
    logic [15:0] ci_pre;
    logic [31:0] d_hold;
    logic        l_hold;
    bit fin, prev_stall, full_rate;
    first_word = 32'd0;
    build_exp(m, n, sh);
    w_cnt = exp_q.size();
    full_rate = !rnd_ready && stall_len == 0 && rst_after < 0;
    got = 0; hs_cyc = -1; first_v = -1; ci_hold = 0; fin = 0; prev_stall = 0;
    d_hold = 32'd0; l_hold = 1'b0;
    ci_pre = C_index;
    M = 8'(m); N = 8'(n); shift = 5'(sh); in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; M = 8'($urandom); N = 8'($urandom); shift = 5'($urandom);
    for (int cyc = 1; cyc <= 1000 && !fin; cyc++) begin
      if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
      else           out_ready = !(cyc >= stall_at && cyc < stall_at + stall_len);
      if (cyc == pulse_at) begin in_valid = 1'b1; M = 8'd1; N = 8'd4; end
      else in_valid = 1'b0;
      if (rst_after >= 0 && got == rst_after) begin rst = 1'b1; out_ready = 1'b0; end
      #1;
      if (rst) begin
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_C_index", C_index, 0);
        return;
      end
      if (cyc == 1) begin
        chk("busy_c1", busy, w_cnt != 0);
        chk("done_c1", done, w_cnt == 0);
        if (w_cnt != 0) chk("cidx_c1", C_index, 0);
        else begin
          chk("cidx_noread", C_index, ci_pre);
          chk("no_valid", out_valid, 0);
        end
      end
      if (out_valid && first_v < 0) first_v = cyc;
      if (full_rate) chk("fullrate_vld", out_valid, (cyc >= 3 && cyc < 3 + w_cnt));
      if (prev_stall && out_valid) begin
        chk("hold_data", out_data, d_hold);
        chk("hold_last", out_last, l_hold);
      end
      if (stall_len > 0) begin
        if (cyc == stall_at + 1) ci_hold = int'(C_index);
        if (cyc > stall_at + 1 && cyc < stall_at + stall_len) chk("cidx_stall", C_index, ci_hold);
        if (cyc == stall_at + stall_len - 1)
          chk("buffered", ci_hold + 1 - got, (w_cnt - got < 2) ? w_cnt - got : 2);
      end
      prev_stall = out_valid && !out_ready;
      d_hold = out_data;
      l_hold = out_last;
      if (out_valid && out_ready) begin
        if (got == 0) first_word = out_data;
        if (got < w_cnt) begin
          chk("data", out_data, exp_q[got]);
          chk("last", out_last, got == w_cnt - 1);
        end else chk("extra_word", got, w_cnt);
        got++;
        if (got == w_cnt) hs_cyc = cyc;
      end
      if (done) begin
        chk("done_time", cyc, (w_cnt == 0) ? 1 : hs_cyc + 1);
        chk("busy_fin", busy, 0);
        fin = 1;
      end
      if (!fin) begin @(posedge clk); #1; end
    end
    chk("done_seen", fin, 1);
    chk("word_count", got, w_cnt);
    if (w_cnt > 0) chk("first_vld", first_v, 3);
    @(posedge clk); #1;
    chk("done_pulse", done, 0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; M = 8'd0; N = 8'd0; shift = 5'd0; out_ready = 1'b0;
    for (int k = 0; k < 256; k++) cmem[k] = 128'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_last", out_last, 0);
    chk("reset_out_data", out_data, 0);
    chk("reset_C_index", C_index, 0);
    chk("reset_C_we", C_we, 0);
    chk("reset_C_din", C_din === 128'd0, 1);
    rst = 1'b0;
    @(posedge clk); #1;

    // Saturation both ways
    cmem[0] = {32'sd300, -32'sd5, 32'sd127, -32'sd200};
    run(1, 4, 0, 0, -1, 0, -1, -1, w0);
`ifdef NPU_C_DRAIN_RELU_EN
    chk("sat_word", w0, 32'h7F007F00);
`else
    chk("sat_word", w0, 32'h7FFB7F80);
`endif

    // Rounding half-up
    cmem[0] = {32'sd0, 32'sd7, -32'sd24, 32'sd24};
    run(1, 4, 4, 0, -1, 0, -1, -1, w0);
`ifdef NPU_C_DRAIN_RELU_EN
    chk("round_word", w0, 32'h00000002);
`else
    chk("round_word", w0, 32'h0000FF02);
`endif

    // Partial last block per row
    fill_rand();
    run(2, 6, 3, 0, -1, 0, -1, -1, w0);

    // Full rate with an ignored start while busy, then a long mid-stream stall
    fill_rand();
    run(2, 16, 2, 0, -1, 0, -1, 4, w0);
    run(2, 16, 5, 0, 5, 10, -1, -1, w0);

    // Empty transfer
    run(0, 5, 0, 0, -1, 0, -1, -1, w0);

    // Reset mid-transfer, then a clean restart
    fill_rand();
    run(4, 8, 1, 0, -1, 0, 2, -1, w0);
    run(4, 8, 1, 0, -1, 0, -1, -1, w0);

    // Random shapes and back-pressure
    for (int t = 0; t < 10; t++) begin
      fill_rand();
      run(int'($urandom_range(0, 4)), int'($urandom_range(0, 20)), int'($urandom_range(0, 31)),
          1, -1, 0, -1, -1, w0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
